reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL select hardwired-zero entry 0 when set: reads return 0 and writes are dropped.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when set.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rstN  in  1  SHALL be the reset: synchronous, active-low.
REQ-007 readRegister1, readRegister2  in  ADDR_W  SHALL be the read addresses for ports 1 and 2.
REQ-008 readData1, readData2  out  DATA_W  SHALL be the registered read data for ports 1 and 2.
REQ-009 regWrite  in  1  SHALL be the write enable.
REQ-010 writeRegister  in  ADDR_W  SHALL be the write address.
REQ-011 writeData  in  DATA_W  SHALL be the write data.
REQ-012 clearReq  in  1  SHALL be a one-cycle request to zero all entries.
REQ-013 ready  out  1  SHALL be high only when the file accepts writes (FSM in IDLE).

Function
REQ-014 Reads SHALL have 1-cycle latency: readDataN at edge k+1 reflects readRegisterN sampled at edge k.
REQ-015 A write SHALL commit at the rising edge where regWrite=1 and ready=1; it is visible to reads sampled at later edges.
REQ-016 With BYPASS=1, if regWrite=1, ready=1 and writeRegister==readRegisterN at the same edge, readDataN SHALL take writeData. Exception: ZERO_REG=1 and address 0 returns 0.
REQ-017 With BYPASS=0, that same-edge read SHALL return the old contents.
REQ-018 Both ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-019 The FSM SHALL have two states: IDLE and CLEAR.
REQ-020 In CLEAR, a counter clrIdx SHALL zero entry clrIdx each cycle, stepping 0 to DEPTH-1.
REQ-021 After the edge that zeroes entry DEPTH-1, the FSM SHALL enter IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-022 In IDLE, clearReq=1 SHALL move the FSM to CLEAR at the next edge with clrIdx=0. A write at that same edge SHALL still commit and is then cleared.
REQ-023 In CLEAR, regWrite SHALL be ignored (write dropped, no bypass) and clearReq SHALL be ignored.
REQ-024 In CLEAR, readData1 and readData2 SHALL register 0.
REQ-025 ready SHALL be a registered decode of the state, with no combinational path from any input.

Reset
REQ-026 At a rising edge with rstN=0: FSM to CLEAR, clrIdx to 0, readData1 and readData2 to 0, ready to 0.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sweep at clrIdx=0.
REQ-028 After rstN deasserts, ready SHALL rise exactly DEPTH cycles later, with all entries reading 0.
REQ-029 Storage SHALL need no initial block; reset plus the sweep defines all contents.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the default DATA_W/ADDR_W constants, reused by the decode and ALU blocks.
REQ-031 A single sub-module, reg_file_read_port, SHALL implement one read port (address mux, bypass compare, zero-reg mask, output register); it is instantiated twice.
REQ-032 Storage SHALL be one DEPTH x DATA_W array with one write port, muxed between the user write and the clear sweep.

Verification
REQ-033 Reset: rstN low 2 cycles then high -> ready rises after 32 cycles; reads of entries 0..31 all return 0.
REQ-034 Write then read: write 0xDEADBEEF to entry 5, read entry 5 on the next cycle -> readData1 = 0xDEADBEEF one cycle later.
REQ-035 Bypass: write 0x12345678 to entry 7 while reading 7 on both ports at the same edge -> both ports = 0x12345678 (BYPASS=1); old value when BYPASS=0.
REQ-036 Zero register: write 0xFFFFFFFF to entry 0 -> reads of 0 return 0; with ZERO_REG=0 they return 0xFFFFFFFF.
REQ-037 Clear: fill entries with nonzero data, pulse clearReq -> ready low 32 cycles, writes dropped, reads 0, then every entry reads 0.
REQ-038 Reset mid-clear and parameters: assert rstN low at sweep index 10 -> the sweep restarts and ready rises 32 cycles after release; repeat REQ-033 to REQ-037 at DATA_W=16, ADDR_W=3 (8-cycle sweep).

Source files
------------

// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the parameterised register file: control FSM states
// and default geometry.
package reg_file_param_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rfState_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: selects a word from the flattened storage, applies
// write forwarding and the hardwired-zero mask, and registers the result.
module reg_file_read_port
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           clearing,
  input  logic [ADDR_W-1:0]              readAddr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  memFlat,
  input  logic                           wrEn,
  input  logic [ADDR_W-1:0]              wrAddr,
  input  logic [DATA_W-1:0]              wrData,
  output logic [DATA_W-1:0]              readData
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] words [DEPTH];
  logic [DATA_W-1:0] readNext;

  for (genvar i = 0; i < DEPTH; i++) begin : gUnpack
    assign words[i] = memFlat[i*DATA_W +: DATA_W];
  end

  // Later overrides win: the clear sweep and the zero entry beat forwarding.
  always_comb begin
    readNext = words[readAddr];
    if (BYPASS != 0 && wrEn && wrAddr == readAddr) readNext = wrData;
    if (ZERO_REG != 0 && readAddr == '0) readNext = '0;
    if (clearing) readNext = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstN) readData <= '0;
    else       readData <= readNext;
  end

endmodule

// File: rtl/reg_file_param.sv
// Two-read, one-write register file with optional zero entry, optional write
// forwarding, and a one-entry-per-cycle clear sweep after reset or on request.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [DATA_W-1:0] writeData,
  input  logic              clearReq,
  output logic              ready
);

  localparam int DEPTH = 2**ADDR_W;

  rfState_e          state, stateNext;
  logic [ADDR_W-1:0] clrIdx, clrIdxNext;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] memFlat;
  logic                    memWe;
  logic [ADDR_W-1:0]       memAddr;
  logic [DATA_W-1:0]       memWData;
  logic                    userWrite;
  logic                    clearing;

  assign clearing  = (state == CLEAR);
  assign userWrite = (state == IDLE) && regWrite;

  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    case (state)
      IDLE: begin
        if (clearReq) begin
          stateNext  = CLEAR;
          clrIdxNext = '0;
        end
      end
      CLEAR: begin
        clrIdxNext = clrIdx + 1'b1;
        if (&clrIdx) stateNext = IDLE;
      end
      default: stateNext = CLEAR;
    endcase
  end

  // ready is registered from the next state so it always equals (state == IDLE).
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= CLEAR;
      clrIdx <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
      ready  <= (stateNext == IDLE);
    end
  end

  always_comb begin
    memWe    = 1'b0;
    memAddr  = writeRegister;
    memWData = writeData;
    if (clearing) begin
      memWe    = 1'b1;
      memAddr  = clrIdx;
      memWData = '0;
    end else if (regWrite && !(ZERO_REG != 0 && writeRegister == '0)) begin
      memWe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstN && memWe) mem[memAddr] <= memWData;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gFlatten
    assign memFlat[i*DATA_W +: DATA_W] = mem[i];
  end

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) readPort1 (
    .clk(clk), .rstN(rstN), .clearing(clearing), .readAddr(readRegister1),
    .memFlat(memFlat), .wrEn(userWrite), .wrAddr(writeRegister),
    .wrData(writeData), .readData(readData1)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) readPort2 (
    .clk(clk), .rstN(rstN), .clearing(clearing), .readAddr(readRegister2),
    .memFlat(memFlat), .wrEn(userWrite), .wrAddr(writeRegister),
    .wrData(writeData), .readData(readData2)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: a default instance and a small 16x8 instance
// without zero entry or forwarding share one stimulus stream.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rstN, regWrite, clearReq;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] wData;

  logic [31:0] rdA1, rdA2;
  logic        readyA;
  logic [15:0] rdB1, rdB2;
  logic        readyB;

  int total = 0;
  int bad   = 0;

  // Reference state, index 0 = default instance, index 1 = small instance.
  logic [31:0] mMem [2][32];
  int          mPos [2];
  bit          mBusy [2];
  logic [31:0] mExp1 [2];
  logic [31:0] mExp2 [2];
  bit          mReady [2];

  always #5 clk = ~clk;

  reg_file_param dutA (
    .clk(clk), .rstN(rstN),
    .readRegister1(rr1), .readRegister2(rr2),
    .readData1(rdA1), .readData2(rdA2),
    .regWrite(regWrite), .writeRegister(wr), .writeData(wData),
    .clearReq(clearReq), .ready(readyA)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rstN(rstN),
    .readRegister1(rr1[2:0]), .readRegister2(rr2[2:0]),
    .readData1(rdB1), .readData2(rdB2),
    .regWrite(regWrite), .writeRegister(wr[2:0]), .writeData(wData[15:0]),
    .clearReq(clearReq), .ready(readyB)
  );

  function automatic int depthOf(input int m);
    return (m == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] maskOf(input int m);
    return (m == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit zeroOf(input int m);
    return m == 0;
  endfunction

  function automatic bit bypassOf(input int m);
    return m == 0;
  endfunction

  function automatic logic [31:0] modelRead(input int m, input int a, input int wa,
                                            input logic [31:0] wd);
    if (zeroOf(m) && a == 0) return 32'h0;
    if (bypassOf(m) && regWrite && wa == a) return wd;
    return mMem[m][a];
  endfunction

  // Advances both references by one rising edge using the currently driven inputs.
  task automatic modelEdge();
    for (int m = 0; m < 2; m++) begin
      int          d  = depthOf(m);
      int          a1 = int'(rr1) % d;
      int          a2 = int'(rr2) % d;
      int          wa = int'(wr) % d;
      logic [31:0] wd = wData & maskOf(m);
      if (!rstN) begin
        mBusy[m] = 1'b1;
        mPos[m]  = 0;
        mExp1[m] = 32'h0;
        mExp2[m] = 32'h0;
      end else if (mBusy[m]) begin
        mExp1[m] = 32'h0;
        mExp2[m] = 32'h0;
        mMem[m][mPos[m]] = 32'h0;
        mPos[m]++;
        if (mPos[m] == d) mBusy[m] = 1'b0;
      end else begin
        mExp1[m] = modelRead(m, a1, wa, wd);
        mExp2[m] = modelRead(m, a2, wa, wd);
        if (regWrite && !(zeroOf(m) && wa == 0)) mMem[m][wa] = wd;
        if (clearReq) begin
          mBusy[m] = 1'b1;
          mPos[m]  = 0;
        end
      end
      mReady[m] = !mBusy[m];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, steps the reference, then compares after the edge.
  task automatic applyStimulus(input logic rst, input logic wrE, input logic clr,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] wa, input logic [31:0] wd);
    rstN = rst; regWrite = wrE; clearReq = clr;
    rr1 = a1; rr2 = a2; wr = wa; wData = wd;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("rdA1", rdA1, mExp1[0]);
    checkOutput("rdA2", rdA2, mExp2[0]);
    checkOutput("rdyA", {31'b0, readyA}, {31'b0, mReady[0]});
    checkOutput("rdB1", {16'b0, rdB1}, mExp1[1]);
    checkOutput("rdB2", {16'b0, rdB2}, mExp2[1]);
    checkOutput("rdyB", {31'b0, readyB}, {31'b0, mReady[1]});
  endtask

  task automatic idleRead(input int a1, input int a2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'(a1), 5'(a2), 5'd0, 32'h0);
  endtask

  task automatic waitReady(input string tag, input int expA, input int expB);
    int kA = -1;
    int kB = -1;
    for (int k = 1; k <= 40; k++) begin
      idleRead($urandom_range(31, 0), $urandom_range(31, 0));
      if (readyA && kA < 0) kA = k;
      if (readyB && kB < 0) kB = k;
    end
    checkOutput({tag, "LatA"}, kA, expA);
    checkOutput({tag, "LatB"}, kB, expB);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 32; i++) mMem[m][i] = 32'h0;

    // Reset for two cycles, then ready after a full sweep.
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    checkOutput("rstRdy", {31'b0, readyA}, 32'h0);
    waitReady("rst", 32, 8);
    for (int i = 0; i < 32; i++) begin
      idleRead(i, 31 - i);
      checkOutput("rstZero1", rdA1, 32'h0);
      checkOutput("rstZero2", rdA2, 32'h0);
    end

    // Write then read back.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 32'hDEAD_BEEF);
    idleRead(5, 1);
    checkOutput("wr5A", rdA1, 32'hDEAD_BEEF);
    checkOutput("wr5B", {16'b0, rdB1}, 32'h0000_BEEF);

    // Same-edge forwarding on both ports.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 32'h1234_5678);
    checkOutput("bypA1", rdA1, 32'h1234_5678);
    checkOutput("bypA2", rdA2, 32'h1234_5678);
    checkOutput("bypB1", {16'b0, rdB1}, 32'h0);
    idleRead(7, 7);
    checkOutput("postBypB", {16'b0, rdB2}, 32'h0000_5678);

    // Entry zero.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
    idleRead(0, 0);
    checkOutput("zeroA", rdA1, 32'h0);
    checkOutput("zeroB", {16'b0, rdB2}, 32'h0000_FFFF);

    // Fill, clear with a same-edge write, random traffic during the sweep.
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 5'(i), 5'(31 - i), 5'(i), i * 32'h0101_0101 + 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 32'hCAFE_F00D);
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
                    5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), $urandom);
      checkOutput("clrRdy", {31'b0, readyA}, (k == 32) ? 32'h1 : 32'h0);
      checkOutput("clrRd", rdA1, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      idleRead(i, i);
      checkOutput("clrAll", rdA2, 32'h0);
    end

    // Reset at sweep index 10 restarts the sweep.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
    for (int k = 0; k < 10; k++) idleRead(k, k);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    waitReady("midClr", 32, 8);

    // Random traffic with occasional clears and resets.
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom_range(199, 0) != 0), 1'($urandom_range(1, 0)),
                    ($urandom_range(39, 0) == 0), 5'($urandom_range(31, 0)),
                    5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
